multicycle_control: RTL and testbench
=====================================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have parameter WAIT_LIMIT, default 16: the maximum number of consecutive mem_ready-low cycles allowed in one memory state.
REQ-002 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have port opcode, input, 6: instruction-register bits [31:26].
REQ-005 SHALL have port zero, input, 1: ALU zero flag.
REQ-006 SHALL have port mem_ready, input, 1: memory access completes in the current cycle.
REQ-007 SHALL have outputs MemRead, MemWrite, IorD, IRWrite, RegWrite, RegDest, MemtoReg, ALUSrcA and pc_en, each 1 bit, as datapath controls.
REQ-008 SHALL have outputs ALUOp, ALUSrcB and PCSource, each 2 bits, as datapath controls.
REQ-009 SHALL have outputs instr_done (1 bit, retire pulse), illegal (1 bit, one-cycle pulse), fault (1 bit, sticky) and state (4 bits, debug).

Function
REQ-010 SHALL implement a Moore FSM with these states: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, JUMP=9, FAULT=15; all other codes go to FAULT.
REQ-011 FETCH SHALL drive MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00, with IRWrite=pc_en=mem_ready; it goes to DECODE on mem_ready and otherwise stays.
REQ-012 DECODE SHALL drive ALUSrcA=0, ALUSrcB=11, ALUOp=00, and branch on opcode: 0x00->EXEC, 0x23/0x2B->MEMADR, 0x04->BRANCH, 0x02->JUMP.
REQ-013 Any other opcode in DECODE SHALL assert illegal for one cycle, assert instr_done, and return to FETCH (treated as a NOP).
REQ-014 MEMADR SHALL drive ALUSrcA=1, ALUSrcB=10, ALUOp=00, then go to MEMRD (0x23) or MEMWR (0x2B).
REQ-015 MEMRD SHALL drive MemRead=1, IorD=1, and go to MEMWB on mem_ready.
REQ-016 MEMWB SHALL drive RegWrite=1, MemtoReg=1, RegDest=0, instr_done=1, then go to FETCH.
REQ-017 MEMWR SHALL drive MemWrite=1, IorD=1, and on mem_ready assert instr_done and go to FETCH.
REQ-018 EXEC SHALL drive ALUSrcA=1, ALUSrcB=00, ALUOp=10, then go to ALUWB.
REQ-019 ALUWB SHALL drive RegWrite=1, RegDest=1, MemtoReg=0, instr_done=1, then go to FETCH.
REQ-020 BRANCH SHALL drive ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSource=01, pc_en=zero, instr_done=1, then go to FETCH.
REQ-021 JUMP SHALL drive PCSource=10, pc_en=1, instr_done=1, then go to FETCH.
REQ-022 Every output not listed for the current state SHALL be 0.
REQ-023 Zero-wait latencies SHALL be: R-type 4, lw 5, sw 4, beq 3, j 3 cycles; each mem_ready-low cycle adds one cycle.
REQ-024 A wait counter SHALL clear on entry to FETCH, MEMRD or MEMWR and increment each cycle mem_ready is low in those states.
REQ-025 When the wait counter reaches WAIT_LIMIT with mem_ready still low, the FSM SHALL go to FAULT instead.
REQ-026 If mem_ready rises in the same cycle the wait counter reaches WAIT_LIMIT, mem_ready SHALL win and the FSM SHALL NOT go to FAULT.
REQ-027 FAULT SHALL drive fault=1 with all control outputs 0, and hold until reset.
REQ-028 state SHALL equal the current state encoding.

Reset
REQ-029 While reset=0, the FSM SHALL be forced asynchronously to FETCH, the wait counter and fault cleared, and every output forced to 0, including state=0.
REQ-030 Reset asserted mid-instruction SHALL abandon the instruction with no RegWrite, MemWrite or pc_en pulse.
REQ-031 The first FETCH outputs SHALL appear in the cycle after reset deasserts.

Structure
REQ-032 State encodings, opcode constants (R=0x00, LW=0x23, SW=0x2B, BEQ=0x04, J=0x02) and ALUOp codes SHALL live in a shared package cpu_pkg.
REQ-033 The wait counter and limit compare SHALL be the single sub-module mc_wait_timer, with ports clk, reset, clear, inc and expired.

Verification
REQ-034 The bench SHALL check: reset release, opcode=0x00, mem_ready=1 -> states 0,1,6,7; RegWrite=1 and RegDest=1 only in cycle 4; instr_done in cycle 4.
REQ-035 The bench SHALL check: opcode=0x23, mem_ready low for 3 cycles in MEMRD -> lw retires in 8 cycles with MemtoReg=1 in MEMWB.
REQ-036 The bench SHALL check: opcode=0x04 with zero=1 then zero=0 -> pc_en=1 in BRANCH in the first case and pc_en=0 in the second, PCSource=01 both.
REQ-037 The bench SHALL check: opcode=0x3F -> illegal pulses once in DECODE and the next cycle is FETCH, with RegWrite=MemWrite=0 throughout.
REQ-038 The bench SHALL check: mem_ready held 0 in FETCH with WAIT_LIMIT=16 -> fault=1 after 16 cycles and state=15 held until reset=0.
REQ-039 The bench SHALL check: reset=0 asserted during MEMWR -> all outputs 0 immediately and state=0, with no MemWrite after release.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared encodings for the multicycle CPU controller: FSM states, opcodes,
// ALU/mux select codes and the bundled control-word struct.
package cpu_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_FAULT  = 4'd15
  } state_t;

  localparam logic [5:0] OP_R   = 6'h00;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_SW  = 6'h2B;
  localparam logic [5:0] OP_BEQ = 6'h04;
  localparam logic [5:0] OP_J   = 6'h02;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_BRIMM = 2'b11;

  localparam logic [1:0] PC_ALU = 2'b00;
  localparam logic [1:0] PC_BR  = 2'b01;
  localparam logic [1:0] PC_JMP = 2'b10;

  typedef struct packed {
    logic       mem_read;
    logic       mem_write;
    logic       iord;
    logic       ir_write;
    logic       reg_write;
    logic       reg_dest;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic       pc_en;
    logic [1:0] alu_op;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
    logic       instr_done;
    logic       illegal;
    logic       fault;
  } ctrl_t;

  // States that wait on memory and are covered by the stall timer.
  function automatic logic is_wait_state(state_t s);
    return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
  endfunction

endpackage

// File: rtl/mc_wait_timer.sv
// Counts consecutive mem_ready-low cycles in a memory state; expired once
// WAIT_LIMIT low cycles have been seen.
module mc_wait_timer #(
  parameter int WAIT_LIMIT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic inc,
  output logic expired
);

  localparam int CW = $clog2(WAIT_LIMIT + 1);

  logic [CW-1:0] cnt;

  assign expired = (cnt == CW'(WAIT_LIMIT));

  // Saturates at the limit so it can never wrap back to a legal count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                cnt <= '0;
    else if (clear)            cnt <= '0;
    else if (inc && !expired)  cnt <= cnt + CW'(1);
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS-subset control FSM with memory stall timeout and sticky
// fault state; outputs decode from the current state.
module multicycle_control
  import cpu_pkg::*;
#(
  parameter int WAIT_LIMIT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IorD,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       RegDest,
  output logic       MemtoReg,
  output logic       ALUSrcA,
  output logic       pc_en,
  output logic [1:0] ALUOp,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSource,
  output logic       instr_done,
  output logic       illegal,
  output logic       fault,
  output logic [3:0] state
);

  state_t st;
  ctrl_t  c;
  logic   waiting, expired, legal;

  assign waiting = is_wait_state(st);
  assign legal   = (opcode == OP_R) || (opcode == OP_LW) || (opcode == OP_SW) ||
                   (opcode == OP_BEQ) || (opcode == OP_J);

  // Cleared whenever outside a wait state or on the completing cycle, so
  // every entry into FETCH/MEMRD/MEMWR starts from zero.
  mc_wait_timer #(.WAIT_LIMIT(WAIT_LIMIT)) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (~waiting | mem_ready),
    .inc     (waiting & ~mem_ready),
    .expired (expired)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st <= S_FETCH;
    end else begin
      case (st)
        S_FETCH:  if (mem_ready) st <= S_DECODE; else if (expired) st <= S_FAULT;
        S_DECODE: begin
          case (opcode)
            OP_R:         st <= S_EXEC;
            OP_LW, OP_SW: st <= S_MEMADR;
            OP_BEQ:       st <= S_BRANCH;
            OP_J:         st <= S_JUMP;
            default:      st <= S_FETCH;
          endcase
        end
        S_MEMADR: st <= (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
        S_MEMRD:  if (mem_ready) st <= S_MEMWB; else if (expired) st <= S_FAULT;
        S_MEMWR:  if (mem_ready) st <= S_FETCH; else if (expired) st <= S_FAULT;
        S_MEMWB, S_EXEC, S_ALUWB, S_BRANCH, S_JUMP:
                  st <= (st == S_EXEC) ? S_ALUWB : S_FETCH;
        S_FAULT:  st <= S_FAULT;
        default:  st <= S_FAULT;
      endcase
    end
  end

  // Gated by reset so nothing reaches the datapath while reset is held.
  always_comb begin
    c = '0;
    if (reset) begin
      case (st)
        S_FETCH: begin
          c.mem_read  = 1'b1;
          c.alu_src_b = SRCB_FOUR;
          c.alu_op    = ALU_ADD;
          c.pc_source = PC_ALU;
          c.ir_write  = mem_ready;
          c.pc_en     = mem_ready;
        end
        S_DECODE: begin
          c.alu_src_b  = SRCB_BRIMM;
          c.alu_op     = ALU_ADD;
          c.illegal    = ~legal;
          c.instr_done = ~legal;
        end
        S_MEMADR: begin
          c.alu_src_a = 1'b1;
          c.alu_src_b = SRCB_IMM;
          c.alu_op    = ALU_ADD;
        end
        S_MEMRD: begin
          c.mem_read = 1'b1;
          c.iord     = 1'b1;
        end
        S_MEMWB: begin
          c.reg_write  = 1'b1;
          c.mem_to_reg = 1'b1;
          c.instr_done = 1'b1;
        end
        S_MEMWR: begin
          c.mem_write  = 1'b1;
          c.iord       = 1'b1;
          c.instr_done = mem_ready;
        end
        S_EXEC: begin
          c.alu_src_a = 1'b1;
          c.alu_src_b = SRCB_REG;
          c.alu_op    = ALU_FUNCT;
        end
        S_ALUWB: begin
          c.reg_write  = 1'b1;
          c.reg_dest   = 1'b1;
          c.instr_done = 1'b1;
        end
        S_BRANCH: begin
          c.alu_src_a  = 1'b1;
          c.alu_src_b  = SRCB_REG;
          c.alu_op     = ALU_SUB;
          c.pc_source  = PC_BR;
          c.pc_en      = zero;
          c.instr_done = 1'b1;
        end
        S_JUMP: begin
          c.pc_source  = PC_JMP;
          c.pc_en      = 1'b1;
          c.instr_done = 1'b1;
        end
        S_FAULT:  c.fault = 1'b1;
        default:  c = '0;
      endcase
    end
  end

  assign MemRead    = c.mem_read;
  assign MemWrite   = c.mem_write;
  assign IorD       = c.iord;
  assign IRWrite    = c.ir_write;
  assign RegWrite   = c.reg_write;
  assign RegDest    = c.reg_dest;
  assign MemtoReg   = c.mem_to_reg;
  assign ALUSrcA    = c.alu_src_a;
  assign pc_en      = c.pc_en;
  assign ALUOp      = c.alu_op;
  assign ALUSrcB    = c.alu_src_b;
  assign PCSource   = c.pc_source;
  assign instr_done = c.instr_done;
  assign illegal    = c.illegal;
  assign fault      = c.fault;
  assign state      = st;

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized bench: per-instruction cycle traces are generated from the
// instruction's phase list and compared cycle by cycle against the DUT.
module tb_multicycle_control;

  localparam logic [5:0] R = 6'h00, LW = 6'h23, SW = 6'h2B, BEQ = 6'h04, J = 6'h02;

  logic       clk = 1'b0;
  logic       reset, zero, mem_ready;
  logic [5:0] opcode;
  logic       MemRead, MemWrite, IorD, IRWrite, RegWrite, RegDest, MemtoReg, ALUSrcA, pc_en;
  logic [1:0] ALUOp, ALUSrcB, PCSource;
  logic       instr_done, illegal, fault;
  logic [3:0] state;

  always #5 clk = ~clk;

  multicycle_control #(.WAIT_LIMIT(16)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .MemRead(MemRead), .MemWrite(MemWrite), .IorD(IorD), .IRWrite(IRWrite),
    .RegWrite(RegWrite), .RegDest(RegDest), .MemtoReg(MemtoReg), .ALUSrcA(ALUSrcA),
    .pc_en(pc_en), .ALUOp(ALUOp), .ALUSrcB(ALUSrcB), .PCSource(PCSource),
    .instr_done(instr_done), .illegal(illegal), .fault(fault), .state(state)
  );

  typedef struct packed {
    logic memrd, memwr, iord, irw, rw, rd, m2r, srca, pcen;
    logic [1:0] aop, srcb, pcs;
    logic done, ill, flt;
    logic [3:0] st;
  } obs_t;

  typedef struct {
    logic [5:0] op;
    bit         mr;
    bit         z;
    obs_t       e;
    int         lat;
    string      tag;
  } cyc_t;

  obs_t got;
  assign got = {MemRead, MemWrite, IorD, IRWrite, RegWrite, RegDest, MemtoReg, ALUSrcA,
                pc_en, ALUOp, ALUSrcB, PCSource, instr_done, illegal, fault, state};

  cyc_t q[$];
  int   checks = 0, fails = 0;
  int   exp_lat = 0, cyc = 0;

  task automatic chk(input string tag, input logic [31:0] g, input logic [31:0] x);
    checks++;
    if (g !== x) begin
      fails++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, g, x, $time);
    end
  endtask

  function automatic obs_t blank(input int st);
    obs_t e = '0;
    e.st = 4'(st);
    return e;
  endfunction

  function automatic bit rb();
    return bit'($urandom % 2);
  endfunction

  // Mostly short stalls, sometimes right at or just under the limit.
  function automatic int rwait();
    int r = int'($urandom_range(0, 9));
    if (r == 9) return 16;
    if (r == 8) return 15;
    return r % 4;
  endfunction

  task automatic add(input logic [5:0] op, input bit mr, input bit z, input obs_t e,
                     input int lat, input string tag);
    cyc_t c;
    c.op = op; c.mr = mr; c.z = z; c.e = e; c.lat = lat; c.tag = tag;
    q.push_back(c);
  endtask

  task automatic fetch_phase(input logic [5:0] op, input int fw, input int lat);
    obs_t e = blank(0);
    e.memrd = 1'b1; e.srcb = 2'b01;
    for (int i = 0; i < fw; i++) add(op, 1'b0, rb(), e, (i == 0) ? lat : 0, "fetch_wait");
    e.irw = 1'b1; e.pcen = 1'b1;
    add(op, 1'b1, rb(), e, (fw == 0) ? lat : 0, "fetch");
  endtask

  task automatic gen_instr(input logic [5:0] op, input int fw, input int mw, input bit z);
    obs_t e;
    int   lat;
    bit   legal = (op == R) || (op == LW) || (op == SW) || (op == BEQ) || (op == J);
    case (op)
      R:       lat = 4;
      LW:      lat = 5 + mw;
      SW:      lat = 4 + mw;
      BEQ, J:  lat = 3;
      default: lat = 2;
    endcase
    fetch_phase(op, fw, lat + fw);
    e = blank(1); e.srcb = 2'b11;
    if (!legal) begin e.ill = 1'b1; e.done = 1'b1; end
    add(op, rb(), rb(), e, 0, "decode");
    if (op == R) begin
      e = blank(6); e.srca = 1'b1; e.aop = 2'b10;
      add(op, rb(), rb(), e, 0, "exec");
      e = blank(7); e.rw = 1'b1; e.rd = 1'b1; e.done = 1'b1;
      add(op, rb(), rb(), e, 0, "aluwb");
    end else if (op == LW || op == SW) begin
      e = blank(2); e.srca = 1'b1; e.srcb = 2'b10;
      add(op, rb(), rb(), e, 0, "memadr");
      e = blank((op == LW) ? 3 : 5);
      e.memrd = (op == LW); e.memwr = (op == SW); e.iord = 1'b1;
      for (int i = 0; i < mw; i++) add(op, 1'b0, rb(), e, 0, "mem_wait");
      if (op == SW) e.done = 1'b1;
      add(op, 1'b1, rb(), e, 0, "mem");
      if (op == LW) begin
        e = blank(4); e.rw = 1'b1; e.m2r = 1'b1; e.done = 1'b1;
        add(op, rb(), rb(), e, 0, "memwb");
      end
    end else if (op == BEQ) begin
      e = blank(8); e.srca = 1'b1; e.aop = 2'b01; e.pcs = 2'b01; e.pcen = z; e.done = 1'b1;
      add(op, rb(), z, e, 0, "branch");
    end else if (op == J) begin
      e = blank(9); e.pcs = 2'b10; e.pcen = 1'b1; e.done = 1'b1;
      add(op, rb(), rb(), e, 0, "jump");
    end
  endtask

  // Drives each queued cycle, checks at the falling edge, advances on the rising edge.
  task automatic run_q();
    cyc_t c;
    while (q.size() > 0) begin
      c = q.pop_front();
      opcode = c.op; mem_ready = c.mr; zero = c.z;
      if (c.lat != 0) begin exp_lat = c.lat; cyc = 0; end
      @(negedge clk);
      cyc++;
      chk(c.tag, {10'b0, got}, {10'b0, c.e});
      if (got.done && exp_lat != 0) begin
        chk("latency", cyc, exp_lat);
        exp_lat = 0;
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    obs_t e;
    logic [5:0] op;
    reset = 1'b0; opcode = R; mem_ready = 1'b1; zero = 1'b1;
    #12;
    chk("reset_outputs", {10'b0, got}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;

    gen_instr(R, 0, 0, 1'b0);    run_q();
    gen_instr(LW, 0, 3, 1'b0);   run_q();
    gen_instr(BEQ, 0, 0, 1'b1);
    gen_instr(BEQ, 0, 0, 1'b0);
    gen_instr(6'h3F, 0, 0, 1'b0);
    run_q();

    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 5))
        0:       op = R;
        1:       op = LW;
        2:       op = SW;
        3:       op = BEQ;
        4:       op = J;
        default: op = 6'($urandom);
      endcase
      gen_instr(op, rwait(), rwait(), rb());
    end
    run_q();

    // One stall cycle beyond the limit in FETCH must trap and stay trapped.
    e = blank(0); e.memrd = 1'b1; e.srcb = 2'b01;
    for (int i = 0; i < 17; i++) add(R, 1'b0, rb(), e, 0, "fetch_stall");
    e = blank(15); e.flt = 1'b1;
    for (int i = 0; i < 6; i++) add(6'($urandom), rb(), rb(), e, 0, "fault_hold");
    run_q();
    reset = 1'b0; #1;
    chk("fault_reset", {10'b0, got}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;

    // Reset landing in the middle of a store.
    fetch_phase(SW, 0, 0);
    e = blank(1); e.srcb = 2'b11;               add(SW, 1'b0, 1'b0, e, 0, "decode");
    e = blank(2); e.srca = 1'b1; e.srcb = 2'b10; add(SW, 1'b0, 1'b0, e, 0, "memadr");
    e = blank(5); e.memwr = 1'b1; e.iord = 1'b1; add(SW, 1'b0, 1'b0, e, 0, "memwr_wait");
    run_q();
    mem_ready = 1'b0;
    #2 reset = 1'b0;
    #1 chk("reset_in_memwr", {10'b0, got}, 32'd0);
    mem_ready = 1'b1;
    @(posedge clk); #1;
    chk("reset_held", {10'b0, got}, 32'd0);
    reset = 1'b1;
    gen_instr(R, 1, 0, 1'b0);
    gen_instr(SW, 0, 1, 1'b0);
    run_q();

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
